relu_pool_writer: RTL and testbench

RELU_POOL_WRITER -- requirements
Module: relu_pool_writer

---
 rtl/relu_pool_writer.sv | 151 +++++++++++++++
 tb/tb_relu_pool_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool_writer.sv
// ReLU + optional 2x2 max-pool row writer: consumes one feature-map row per
// beat and emits registered memory writes of 16-bit unsigned activations.
module relu_pool_writer #(
  parameter int LANES = 28,
  parameter int DW    = 17,
  parameter int AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pool_en,
  input  logic [7:0]            num_rows,
  input  logic [AW-1:0]         base_addr,
  input  logic                  in_vld,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [LANES*16-1:0]   wr_data,
  output logic                  busy,
  output logic                  done
);

  // state  | meaning
  // IDLE   | waiting for start
  // ROW_A  | next beat is an even row (or any row when not pooling)
  // ROW_B  | next beat completes a pooled row pair and writes it
  // DONE   | one-cycle done pulse, then IDLE
  typedef enum logic [1:0] {S_IDLE, S_ROW_A, S_ROW_B, S_DONE} state_t;

  localparam int HL = LANES / 2;

  state_t                   state_q;
  logic                     pool_q;
  logic [7:0]               rows_q;
  logic [7:0]               row_cnt_q;
  logic [7:0]               row_cnt_d;
  logic                     last_d;
  logic [AW-1:0]            base_q;
  logic [AW-1:0]            wr_idx_q;
  logic [HL-1:0][15:0]      hrow_q;

  logic                     wr_en_q;
  logic [AW-1:0]            wr_addr_q;
  logic [LANES*16-1:0]      wr_data_q;
  logic                     busy_q;
  logic                     done_q;

  logic [LANES-1:0][15:0]   relu_d;
  logic [HL-1:0][15:0]      pair_d;
  logic [LANES-1:0][15:0]   pool_d;

  always_comb begin
    relu_d = '0;
    pair_d = '0;
    pool_d = '0;
    for (int k = 0; k < LANES; k++) begin
      relu_d[k] = in_data[k*DW+DW-1] ? 16'd0 : in_data[k*DW +: 16];
    end
    // upper half of pool_d stays zero: a pooled row only fills LANES/2 lanes
    for (int j = 0; j < HL; j++) begin
      pair_d[j] = (relu_d[2*j] > relu_d[2*j+1]) ? relu_d[2*j] : relu_d[2*j+1];
      pool_d[j] = (hrow_q[j] > pair_d[j]) ? hrow_q[j] : pair_d[j];
    end
  end

  assign row_cnt_d = row_cnt_q + 8'd1;
  assign last_d    = (row_cnt_d == rows_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_cnt_q <= '0;
      wr_idx_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pool_q    <= pool_en;
            rows_q    <= num_rows;
            base_q    <= base_addr;
            row_cnt_q <= '0;
            wr_idx_q  <= '0;
            if (num_rows == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ROW_A;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ROW_A: begin
          if (in_vld) begin
            row_cnt_q <= row_cnt_d;
            if (pool_q) begin
              hrow_q <= pair_d;
              if (last_d) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ROW_B;
              end
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q + wr_idx_q;
              wr_data_q <= relu_d;
              wr_idx_q  <= wr_idx_q + 1'b1;
              if (last_d) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_ROW_B: begin
          if (in_vld) begin
            row_cnt_q <= row_cnt_d;
            wr_en_q   <= 1'b1;
            wr_addr_q <= base_q + wr_idx_q;
            wr_data_q <= pool_d;
            wr_idx_q  <= wr_idx_q + 1'b1;
            if (last_d) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ROW_A;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_relu_pool_writer.sv
// Self-checking bench for relu_pool_writer: directed cases plus randomized
// passes compared against a row-level reference model.
module tb_relu_pool_writer;
  localparam int LANES = 28;
  localparam int DW    = 17;
  localparam int AW    = 10;
  localparam int HL    = LANES / 2;
  localparam int WW    = LANES * 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 pool_en;
  logic [7:0]           num_rows;
  logic [AW-1:0]        base_addr;
  logic                 in_vld;
  logic [LANES*DW-1:0]  in_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WW-1:0]        wr_data;
  logic                 busy;
  logic                 done;

  relu_pool_writer #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pool_en(pool_en),
    .num_rows(num_rows), .base_addr(base_addr), .in_vld(in_vld),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  wr_t act_q[$];
  wr_t prev_q[$];
  wr_t saved_q[$];
  int  done_q[$];
  int  beats[$];
  logic [LANES*DW-1:0] rows[$];
  int  start_cyc;
  bit  cur_pool;
  int  cur_n;
  logic [AW-1:0] cur_base;

  // writes and done pulses stamped with the index of the edge that produced them
  always @(posedge clk) begin
    wr_t w;
    cyc++;
    #1;
    if (wr_en) begin
      w.c = cyc; w.a = wr_addr; w.d = wr_data;
      act_q.push_back(w);
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane_relu(input logic [LANES*DW-1:0] r, input int k);
    logic [DW-1:0] v;
    v = r[k*DW +: DW];
    if ($signed(v) < 0) return 16'd0;
    return v[15:0];
  endfunction

  function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? a : b;
  endfunction

  function automatic logic [LANES*DW-1:0] rand_row();
    logic [LANES*DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; in_vld = 1'b0; in_data = rand_row();
    end
  endtask

  task automatic do_start(input bit p, input int n, input int b);
    @(negedge clk);
    start = 1'b1; pool_en = p; num_rows = 8'(n); base_addr = AW'(b);
    in_vld = 1'b0;
    start_cyc = cyc + 1;
    cur_pool = p; cur_n = n; cur_base = AW'(b);
    beats.delete();
  endtask

  task automatic beat(input logic [LANES*DW-1:0] d);
    @(negedge clk);
    chk("busy_in_pass", WW'(busy), WW'(1));
    start = 1'b0; in_vld = 1'b1; in_data = d;
    beats.push_back(cyc + 1);
  endtask

  task automatic gap(input bit inj);
    @(negedge clk);
    start = inj; in_vld = 1'b0; in_data = rand_row();
    if (inj) begin
      pool_en = ~cur_pool; num_rows = 8'($urandom_range(1, 9));
      base_addr = AW'($urandom);
    end
  endtask

  task automatic finish_pass(input string name);
    wr_t ex[$];
    wr_t w;
    int  exp_done;
    logic [15:0] m;
    idle(5);
    if (!cur_pool) begin
      for (int i = 0; i < cur_n; i++) begin
        w.d = '0;
        for (int k = 0; k < LANES; k++) w.d[k*16 +: 16] = lane_relu(rows[i], k);
        w.a = AW'(int'(cur_base) + i);
        w.c = beats[i];
        ex.push_back(w);
      end
    end else begin
      for (int p = 0; p < cur_n / 2; p++) begin
        w.d = '0;
        for (int j = 0; j < HL; j++) begin
          m = 16'd0;
          for (int r = 0; r < 2; r++)
            for (int t = 0; t < 2; t++) m = mx(m, lane_relu(rows[2*p+r], 2*j+t));
          w.d[j*16 +: 16] = m;
        end
        w.a = AW'(int'(cur_base) + p);
        w.c = beats[2*p+1];
        ex.push_back(w);
      end
    end
    exp_done = (cur_n == 0) ? start_cyc : beats[cur_n-1];
    chk({name, "_nwr"}, WW'(act_q.size()), WW'(ex.size()));
    for (int i = 0; i < ex.size() && i < act_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), WW'(act_q[i].a), WW'(ex[i].a));
      chk($sformatf("%s_data%0d", name, i), act_q[i].d, ex[i].d);
      chk($sformatf("%s_cyc%0d", name, i), WW'(act_q[i].c), WW'(ex[i].c));
    end
    chk({name, "_ndone"}, WW'(done_q.size()), WW'(1));
    if (done_q.size() > 0) chk({name, "_done_cyc"}, WW'(done_q[0]), WW'(exp_done));
    prev_q = act_q;
    act_q.delete();
    done_q.delete();
  endtask

  // gmode: 0 no gaps, 1 cycle through 0/1/7, 2 random 0..3
  task automatic run_pass(input string name, input bit p, input int b, input int gmode, input bit inj);
    int g;
    int gl[3] = '{0, 1, 7};
    act_q.delete();
    done_q.delete();
    do_start(p, rows.size(), b);
    for (int i = 0; i < rows.size(); i++) begin
      g = (gmode == 0) ? 0 : (gmode == 1) ? gl[i % 3] : int'($urandom_range(0, 3));
      for (int q = 0; q < g; q++) gap(inj);
      beat(rows[i]);
    end
    finish_pass(name);
  endtask

  initial begin
    logic [LANES*DW-1:0] r;
    rst = 1'b1; start = 1'b0; pool_en = 1'b0; num_rows = '0; base_addr = '0;
    in_vld = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", WW'(wr_en), WW'(0));
    chk("rst_wr_addr", WW'(wr_addr), WW'(0));
    chk("rst_wr_data", wr_data, WW'(0));
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_done", WW'(done), WW'(0));
    rst = 1'b0;
    act_q.delete(); done_q.delete();

    // beats while idle must not write
    repeat (3) begin
      @(negedge clk); in_vld = 1'b1; in_data = rand_row();
    end
    idle(3);
    chk("idle_vld_wr", WW'(act_q.size()), WW'(0));
    chk("idle_vld_done", WW'(done_q.size()), WW'(0));

    rows.delete();
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'(k - 3);
    rows.push_back(r); rows.push_back(r);
    run_pass("relu2", 1'b0, 5, 0, 1'b0);

    rows.delete();
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'(k);
    rows.push_back(r);
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'(100 - k);
    rows.push_back(r);
    run_pass("pool2", 1'b1, 40, 0, 1'b0);

    rows.delete();
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = DW'(-5);
    repeat (3) rows.push_back(r);
    run_pass("pool3odd", 1'b1, 12, 0, 1'b0);

    rows.delete();
    rows.push_back(rand_row()); rows.push_back(rand_row());
    run_pass("wrap", 1'b0, (1 << AW) - 1, 0, 1'b0);

    rows.delete();
    run_pass("zero_rows", 1'b1, 3, 0, 1'b0);

    // abort a pooled pass after its first beat
    act_q.delete(); done_q.delete();
    rows.delete();
    do_start(1'b1, 2, 7);
    beat(rand_row());
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in_vld = 1'b1; in_data = rand_row();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_vld = 1'b0;
    idle(4);
    chk("abort_wr", WW'(act_q.size()), WW'(0));
    chk("abort_done", WW'(done_q.size()), WW'(0));
    chk("abort_busy", WW'(busy), WW'(0));
    rows.push_back(rand_row()); rows.push_back(rand_row());
    run_pass("after_abort", 1'b1, 9, 0, 1'b0);

    rows.delete();
    repeat (5) rows.push_back(rand_row());
    run_pass("nogap", 1'b1, 20, 0, 1'b0);
    saved_q = prev_q;
    run_pass("gaps", 1'b1, 20, 1, 1'b1);
    chk("gaps_vs_nogap_n", WW'(prev_q.size()), WW'(saved_q.size()));
    for (int i = 0; i < saved_q.size() && i < prev_q.size(); i++) begin
      chk($sformatf("gaps_vs_nogap_a%0d", i), WW'(prev_q[i].a), WW'(saved_q[i].a));
      chk($sformatf("gaps_vs_nogap_d%0d", i), prev_q[i].d, saved_q[i].d);
    end

    for (int t = 0; t < 8; t++) begin
      rows.delete();
      repeat ($urandom_range(0, 6)) rows.push_back(rand_row());
      run_pass($sformatf("rand%0d", t), 1'($urandom), int'($urandom_range(0, (1 << AW) - 1)), 2, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
